timer_arbiter: RTL and testbench

Shares a single programmable down-counter between NUM_REQ requesters that each need a one-shot delay of a requester-specified number of cycles. A round-robin arbiter grants the counter to one requester at a time, loads that requester's cycle count, counts down to zero and returns a one-cycle done pulse to the owner. The block sits between delay-consuming controllers (retry back-off, settle timers, watchdog-style waits) and the counting datapath, so only one WIDTH-bit counter is instantiated per group.

---
 rtl/timer_arbiter_pkg.sv | 12 +
 rtl/timer_arbiter_rr_arbiter.sv | 26 ++
 rtl/timer_arbiter.sv | 77 +++++++
 tb/tb_timer_arbiter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/timer_arbiter_pkg.sv
// timer_arbiter_pkg: shared state type, limits and one-hot helper for timer_arbiter
package timer_arbiter_pkg;
    typedef enum logic {IDLE, COUNT} state_t;
    localparam int MAX_REQ = 16;
    localparam int IDX_W = $clog2(MAX_REQ);
    function automatic logic [MAX_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [MAX_REQ-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction
endpackage

// File: rtl/timer_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker, first set request at or after i_ptr
module rr_arbiter
    import timer_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IW-1:0]      i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IW-1:0]      o_idx,
    output logic               o_valid
);
    logic [IW-1:0] w_j;
    always_comb begin
        o_idx = '0;
        w_j = '0;
        // scan farthest-first so the nearest set bit from i_ptr is written last
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_j = IW'((int'(i_ptr) + k) % NUM_REQ);
            if (i_req[w_j]) o_idx = w_j;
        end
        o_valid = |i_req;
        o_grant = o_valid ? NUM_REQ'(onehot(IDX_W'(o_idx))) : '0;
    end
endmodule

// File: rtl/timer_arbiter.sv
// timer_arbiter: one shared down-counter granted round-robin; TIMER_ARB_CANCEL_EN aborts on owner req drop
module timer_arbiter
    import timer_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH = 16
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic [NUM_REQ-1:0]              i_req,
    input  logic [NUM_REQ-1:0][WIDTH-1:0]   i_cycles,
    output logic [NUM_REQ-1:0]              o_grant,
    output logic [NUM_REQ-1:0]              o_done,
    output logic                            o_busy
);
    localparam int IW = $clog2(NUM_REQ);
    state_t             r_state, w_state;
    logic [WIDTH-1:0]   r_count, w_count;
    logic [IW-1:0]      r_ptr, w_ptr;
    logic [NUM_REQ-1:0] r_grant, w_grant, r_done, w_done, w_win;
    logic [IW-1:0]      w_idx;
    logic               w_valid, w_cancel;
    rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
        .i_req   (i_req),
        .i_ptr   (r_ptr),
        .o_grant (w_win),
        .o_idx   (w_idx),
        .o_valid (w_valid)
    );
`ifdef TIMER_ARB_CANCEL_EN
    assign w_cancel = ~|(i_req & r_grant);
`else
    assign w_cancel = 1'b0;
`endif
    always_comb begin
        w_state = r_state;
        w_count = r_count;
        w_ptr = r_ptr;
        w_grant = r_grant;
        w_done = '0;
        if (r_state == IDLE) begin
            if (w_valid) begin
                w_state = COUNT;
                w_grant = w_win;
                w_count = i_cycles[w_idx];
                w_ptr = (w_idx == IW'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
            end
        end else if (w_cancel) begin
            w_state = IDLE;
            w_grant = '0;
        end else if (r_count != '0) begin
            w_count = r_count - 1'b1;
        end else begin
            w_state = IDLE;
            w_grant = '0;
            w_done = r_grant;
        end
    end
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_count <= '0;
            r_ptr <= '0;
            r_grant <= '0;
            r_done <= '0;
        end else begin
            r_state <= w_state;
            r_count <= w_count;
            r_ptr <= w_ptr;
            r_grant <= w_grant;
            r_done <= w_done;
        end
    end
    assign o_grant = r_grant;
    assign o_done = r_done;
    assign o_busy = (r_state == COUNT);
endmodule

// File: tb/tb_timer_arbiter.sv
// tb_timer_arbiter: scoreboard bench for timer_arbiter with NUM_REQ=4, WIDTH=4
module tb_timer_arbiter;
    typedef struct {
        logic [3:0] mask;
        bit         is_done;
        int         cyc;
    } ev_t;
    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [3:0]       req = '0;
    logic [3:0][3:0]  cycles = '0;
    logic [3:0]       grant, done;
    logic             busy;
    int               cyc = 0;
    int               checks = 0;
    int               failures = 0;
    ev_t              q[$];
    logic [3:0]       prev_grant = '0;

    timer_arbiter #(.NUM_REQ(4), .WIDTH(4)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_req    (req),
        .i_cycles (cycles),
        .o_grant  (grant),
        .o_done   (done),
        .o_busy   (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [3:0] m, input bit d, input int c);
        ev_t e;
        e.mask = m;
        e.is_done = d;
        e.cyc = c;
        q.push_back(e);
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        check("reset_grant", grant, 4'b0);
        check("reset_done", done, 4'b0);
        check("reset_busy", {3'b0, busy}, 4'b0);
    endtask

    task automatic single(input int i, input int c);
        int t;
        cycles[i] = 4'(c);
        req[i] = 1'b1;
        t = cyc;
        push(4'(1 << i), 1'b0, t + 1);
        push(4'(1 << i), 1'b1, t + c + 2);
        repeat (c + 2) tick();
        req[i] = 1'b0;
        tick();
    endtask

    task automatic report(input string name, input ev_t e, input logic [3:0] m, input bit d);
        checks++;
        if (e.mask !== m || e.is_done != d || e.cyc != cyc) begin
            failures++;
            $display("FAIL %s: got mask=%b done=%0d cycle=%0d expected mask=%b done=%0d cycle=%0d",
                     name, m, d, cyc, e.mask, e.is_done, e.cyc);
        end
    endtask

    task automatic observe(input logic [3:0] m, input bit d);
        if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event: got mask=%b done=%0d cycle=%0d expected none", m, d, cyc);
        end else begin
            report(d ? "done_event" : "grant_event", q.pop_front(), m, d);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (busy !== (grant != 4'b0)) begin
                failures++;
                $display("FAIL busy_vs_grant: got busy=%b grant=%b expected busy=%b", busy, grant, grant != 4'b0);
            end
            if (grant != 4'b0 && grant != prev_grant) observe(grant, 1'b0);
            if (done != 4'b0) observe(done, 1'b1);
        end
        prev_grant = grant;
    end

    initial begin
        int t;
        tick();
        do_reset();
        // single request, then zero and maximum delay
        single(1, 5);
        single(0, 0);
        single(2, 15);
        // contention: all held with 2-cycle delays, expect 0,1,2,3,0
        do_reset();
        cycles = {4'd2, 4'd2, 4'd2, 4'd2};
        req = 4'b1111;
        t = cyc;
        for (int k = 0; k < 5; k++) begin
            push(4'(1 << (k % 4)), 1'b0, t + 1 + 4 * k);
            push(4'(1 << (k % 4)), 1'b1, t + 4 + 4 * k);
        end
        repeat (20) tick();
        req = 4'b0;
        tick();
        // fairness: req[2] joins while 0 counts, wins before 0 is re-granted
        do_reset();
        cycles[0] = 4'd3;
        cycles[2] = 4'd1;
        req[0] = 1'b1;
        t = cyc;
        push(4'b0001, 1'b0, t + 1);
        push(4'b0001, 1'b1, t + 5);
        push(4'b0100, 1'b0, t + 6);
        push(4'b0100, 1'b1, t + 8);
        push(4'b0001, 1'b0, t + 9);
        push(4'b0001, 1'b1, t + 13);
        tick();
        tick();
        req[2] = 1'b1;
        repeat (6) tick();
        req[2] = 1'b0;
        repeat (5) tick();
        req[0] = 1'b0;
        tick();
        // reset mid-count abandons the delay and rewinds the pointer
        cycles[1] = 4'd10;
        req[1] = 1'b1;
        t = cyc;
        push(4'b0010, 1'b0, t + 1);
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        check("midreset_grant", grant, 4'b0);
        check("midreset_done", done, 4'b0);
        check("midreset_busy", {3'b0, busy}, 4'b0);
        rst_n = 1'b1;
        cycles[0] = 4'd1;
        req[0] = 1'b1;
        t = cyc;
        push(4'b0001, 1'b0, t + 1);
        push(4'b0001, 1'b1, t + 3);
        push(4'b0010, 1'b0, t + 4);
        push(4'b0010, 1'b1, t + 15);
        repeat (3) tick();
        req[0] = 1'b0;
        repeat (12) tick();
        req[1] = 1'b0;
        tick();
        // owner withdraws mid-count
        cycles[3] = 4'd8;
        req[3] = 1'b1;
        t = cyc;
        push(4'b1000, 1'b0, t + 1);
`ifndef TIMER_ARB_CANCEL_EN
        push(4'b1000, 1'b1, t + 10);
`endif
        repeat (3) tick();
        req[3] = 1'b0;
        tick();
`ifdef TIMER_ARB_CANCEL_EN
        check("cancel_grant", grant, 4'b0);
        check("cancel_busy", {3'b0, busy}, 4'b0);
`else
        check("nocancel_grant", grant, 4'b1000);
        check("nocancel_busy", {3'b0, busy}, 4'b0001);
`endif
        repeat (10) tick();
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL pending_events: got %0d outstanding expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
